// File: rtl/spi_rx_word_assembler_if.sv
// Serial-in / parallel-word-out bundle for the SPI receive word assembler.
// The master drives the serial bit stream, and the slave returns the assembled words and frame status.
interface spi_rx_word_assembler_if;
   logic        RX_DATA;
   logic        RX_LOAD;
   logic        RX_STOP;
   logic [15:0] P_DATA;
   logic        P_ENA;
   logic [2:0]  P_ADDR;
   logic        FRAME_DONE;
   logic        FRAME_ERR;
   logic [7:0]  WORD_CNT;

   modport master (
      output RX_DATA, RX_LOAD, RX_STOP,
      input  P_DATA, P_ENA, P_ADDR, FRAME_DONE, FRAME_ERR, WORD_CNT
   );

   modport slave (
      input  RX_DATA, RX_LOAD, RX_STOP,
      output P_DATA, P_ENA, P_ADDR, FRAME_DONE, FRAME_ERR, WORD_CNT
   );
endinterface

// File: rtl/spi_rx_word_assembler.sv
// Assembles a gated serial bit stream into 16-bit words and presents each word with a one-cycle strobe.
// Frames end on RX_STOP; overlong frames are dropped. There is no output backpressure.
module spi_rx_word_assembler #(
   parameter bit         MSB_FIRST = 1'b1,
   parameter logic [7:0] MAX_WORDS = 8'd255
) (
   input logic                   RX_CLK,
   input logic                   RST,
   spi_rx_word_assembler_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

   state_t      state, state_nxt;
   logic [15:0] shift_q, shift_nxt, shifted;
   logic [3:0]  bit_cnt, bit_cnt_nxt;
   logic [7:0]  words, words_nxt;
   logic [2:0]  idx, idx_nxt;
   logic [15:0] p_data_nxt;
   logic [2:0]  p_addr_nxt;
   logic        p_ena_nxt;
   logic        done_nxt;
   logic        err_nxt;
   logic [7:0]  word_cnt_nxt;

   assign shifted = MSB_FIRST ? {shift_q[14:0], bus.RX_DATA} : {bus.RX_DATA, shift_q[15:1]};

   always_comb begin
      state_nxt    = state;
      shift_nxt    = shift_q;
      bit_cnt_nxt  = bit_cnt;
      words_nxt    = words;
      idx_nxt      = idx;
      p_data_nxt   = bus.P_DATA;
      p_addr_nxt   = bus.P_ADDR;
      p_ena_nxt    = 1'b0;
      done_nxt     = 1'b0;
      err_nxt      = 1'b0;
      word_cnt_nxt = bus.WORD_CNT;
      case (state)
         IDLE: begin
            // A stop in IDLE wins over a simultaneous bit: an empty frame has no effect.
            if (bus.RX_LOAD && !bus.RX_STOP) begin
               shift_nxt   = shifted;
               bit_cnt_nxt = 4'd1;
               state_nxt   = RECV;
            end
         end
         RECV: begin
            if (bus.RX_LOAD) begin
               shift_nxt   = shifted;
               bit_cnt_nxt = bit_cnt + 4'd1;
               if (bit_cnt == 4'd15) begin
                  p_data_nxt = shifted;
                  p_addr_nxt = idx;
                  p_ena_nxt  = 1'b1;
                  idx_nxt    = idx + 3'd1;
                  words_nxt  = words + 8'd1;
                  if (words_nxt == MAX_WORDS) state_nxt = DROP;
               end
            end
            // Stop is judged after this edge's bit, so a completing bit ends the frame cleanly.
            if (bus.RX_STOP) begin
               word_cnt_nxt = words_nxt;
               if (bit_cnt_nxt == 4'd0) done_nxt = 1'b1;
               else                     err_nxt  = 1'b1;
               state_nxt   = IDLE;
               shift_nxt   = 16'h0000;
               bit_cnt_nxt = 4'd0;
               words_nxt   = 8'd0;
               idx_nxt     = 3'd0;
            end
         end
         DROP: begin
            if (bus.RX_STOP) begin
               err_nxt      = 1'b1;
               word_cnt_nxt = words;
               state_nxt    = IDLE;
               shift_nxt    = 16'h0000;
               bit_cnt_nxt  = 4'd0;
               words_nxt    = 8'd0;
               idx_nxt      = 3'd0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge RX_CLK or negedge RST) begin
      if (!RST) begin
         state   <= IDLE;
         shift_q <= 16'h0000;
         bit_cnt <= 4'd0;
         words   <= 8'd0;
         idx     <= 3'd0;
      end else begin
         state   <= state_nxt;
         shift_q <= shift_nxt;
         bit_cnt <= bit_cnt_nxt;
         words   <= words_nxt;
         idx     <= idx_nxt;
      end
   end

   always_ff @(posedge RX_CLK or negedge RST) begin
      if (!RST) begin
         bus.P_DATA     <= 16'h0000;
         bus.P_ENA      <= 1'b0;
         bus.P_ADDR     <= 3'd0;
         bus.FRAME_DONE <= 1'b0;
         bus.FRAME_ERR  <= 1'b0;
         bus.WORD_CNT   <= 8'd0;
      end else begin
         bus.P_DATA     <= p_data_nxt;
         bus.P_ENA      <= p_ena_nxt;
         bus.P_ADDR     <= p_addr_nxt;
         bus.FRAME_DONE <= done_nxt;
         bus.FRAME_ERR  <= err_nxt;
         bus.WORD_CNT   <= word_cnt_nxt;
      end
   end

endmodule
